// File: rtl/cdb_arbiter_if.sv
// Completion-source offers into the CDB arbiter and the registered CDB broadcast out of it.
// slave = arbiter side, master = completion sources plus ROB/snoop consumers.
interface cdb_arbiter_if #(
    parameter int DEST_BIT = 4,
    parameter int DATA_W   = 32
);
    logic                rs_valid;
    logic [DATA_W-1:0]   rs_value;
    logic [DEST_BIT-1:0] rs_dest;
    logic                rs_ready;

    logic                lb_valid;
    logic [DATA_W-1:0]   lb_value;
    logic [DEST_BIT-1:0] lb_dest;
    logic                lb_ready;

    logic                sb_valid;
    logic [DEST_BIT-1:0] sb_dest;
    logic                sb_ready;

    logic                cdb_valid;
    logic [DATA_W-1:0]   cdb_value;
    logic [DEST_BIT-1:0] cdb_dest;
    logic [1:0]          cdb_src;

    modport slave (
        input  rs_valid, rs_value, rs_dest,
        output rs_ready,
        input  lb_valid, lb_value, lb_dest,
        output lb_ready,
        input  sb_valid, sb_dest,
        output sb_ready,
        output cdb_valid, cdb_value, cdb_dest, cdb_src
    );

    modport master (
        output rs_valid, rs_value, rs_dest,
        input  rs_ready,
        output lb_valid, lb_value, lb_dest,
        input  lb_ready,
        output sb_valid, sb_dest,
        input  sb_ready,
        input  cdb_valid, cdb_value, cdb_dest, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between rs/lb/sb, one holding slot each.
// Latency: accept at edge N -> CDB after edge N+1; no CDB back-pressure, sources stall via *_ready.
module cdb_arbiter #(
    parameter int DEST_BIT = 4,
    parameter int DATA_W   = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_all,
    cdb_arbiter_if.slave  bus
);
    localparam int NSRC = 3;

    typedef struct packed {
        logic [DATA_W-1:0]   value;
        logic [DEST_BIT-1:0] dest;
    } entry_t;

    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   value;
        logic [DEST_BIT-1:0] dest;
        logic [1:0]          src;
    } cdb_t;

    entry_t            slot [NSRC];
    logic [NSRC-1:0]   slot_v;
    logic [1:0]        rr_ptr;
    cdb_t              cdb_q;

    entry_t            offer [NSRC];
    logic [NSRC-1:0]   offer_v;
    logic [1:0]        order [NSRC];
    logic [NSRC-1:0]   grant;
    logic [1:0]        win;
    logic [NSRC-1:0]   ready;
    logic [NSRC-1:0]   accept;
    logic              active;

    assign active = rdy_in & ~clear_all;

    always_comb begin
        offer_v  = {bus.sb_valid, bus.lb_valid, bus.rs_valid};
        offer[0] = '{value: bus.rs_value, dest: bus.rs_dest};
        offer[1] = '{value: bus.lb_value, dest: bus.lb_dest};
        // store completions carry no data
        offer[2] = '{value: '0, dest: bus.sb_dest};
    end

    always_comb begin
        case (rr_ptr)
            2'd1:    order = '{2'd1, 2'd2, 2'd0};
            2'd2:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    always_comb begin
        grant = '0;
        win   = 2'd0;
        if (active) begin
            for (int k = 0; k < NSRC; k++) begin
                if (grant == '0 && slot_v[order[k]]) begin
                    grant[order[k]] = 1'b1;
                    win             = order[k];
                end
            end
        end
    end

    // A slot being drained this cycle may take a new entry in the same edge.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ready[i]  = active & (~slot_v[i] | grant[i]);
            accept[i] = offer_v[i] & ready[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_v <= '0;
            rr_ptr <= 2'd0;
            cdb_q  <= '0;
            for (int i = 0; i < NSRC; i++) begin
                slot[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_all) begin
                slot_v      <= '0;
                rr_ptr      <= 2'd0;
                cdb_q.valid <= 1'b0;
            end else begin
                for (int i = 0; i < NSRC; i++) begin
                    if (accept[i]) begin
                        slot_v[i] <= 1'b1;
                        slot[i]   <= offer[i];
                    end else if (grant[i]) begin
                        slot_v[i] <= 1'b0;
                    end
                end
                if (|grant) begin
                    cdb_q.valid <= 1'b1;
                    cdb_q.value <= slot[win].value;
                    cdb_q.dest  <= slot[win].dest;
                    cdb_q.src   <= win;
                    rr_ptr      <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                end else begin
                    cdb_q.valid <= 1'b0;
                end
            end
        end
    end

    assign bus.rs_ready  = ready[0];
    assign bus.lb_ready  = ready[1];
    assign bus.sb_ready  = ready[2];
    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_value = cdb_q.value;
    assign bus.cdb_dest  = cdb_q.dest;
    assign bus.cdb_src   = cdb_q.src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against a pending-set model.
module tb_cdb_arbiter;
    localparam int DEST_BIT = 4;
    localparam int DATA_W   = 32;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic clear_all;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter_if #(.DEST_BIT(DEST_BIT), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.DEST_BIT(DEST_BIT), .DATA_W(DATA_W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .clear_all (clear_all),
        .bus       (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Model: which sources hold an undelivered result, plus the expected CDB register.
    bit          m_pend [3];
    int unsigned m_val  [3];
    int unsigned m_dst  [3];
    int          m_next;
    bit          m_cv;
    int unsigned m_cval;
    int unsigned m_cdst;
    int unsigned m_csrc;

    function automatic int pick();
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (m_next + k) % 3;
            if (m_pend[s]) return s;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input bit rv, input int unsigned rval, input int unsigned rd,
                         input bit lv, input int unsigned lval, input int unsigned ld,
                         input bit sv, input int unsigned sd);
        bus.rs_valid = rv;
        bus.rs_value = rval;
        bus.rs_dest  = rd[DEST_BIT-1:0];
        bus.lb_valid = lv;
        bus.lb_value = lval;
        bus.lb_dest  = ld[DEST_BIT-1:0];
        bus.sb_valid = sv;
        bus.sb_dest  = sd[DEST_BIT-1:0];
    endtask

    task automatic idle();
        offer(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check readiness before the edge, advance the model, check the CDB after it.
    task automatic tick();
        int          w;
        bit          act;
        bit [2:0]    rexp;
        bit [2:0]    vin;
        int unsigned ival [3];
        int unsigned idst [3];
        #1;
        act = rdy_in && !clear_all;
        w   = act ? pick() : -1;
        for (int i = 0; i < 3; i++) rexp[i] = act && (!m_pend[i] || w == i);
        if (!rst_in) begin
            chk("rs_ready", {63'd0, bus.rs_ready}, {63'd0, rexp[0]});
            chk("lb_ready", {63'd0, bus.lb_ready}, {63'd0, rexp[1]});
            chk("sb_ready", {63'd0, bus.sb_ready}, {63'd0, rexp[2]});
        end
        vin  = {bus.sb_valid, bus.lb_valid, bus.rs_valid};
        ival = '{bus.rs_value, bus.lb_value, 0};
        idst = '{32'(bus.rs_dest), 32'(bus.lb_dest), 32'(bus.sb_dest)};
        @(posedge clk_in);
        if (rst_in) begin
            m_pend = '{0, 0, 0};
            m_next = 0;
            m_cv = 0; m_cval = 0; m_cdst = 0; m_csrc = 0;
        end else if (rdy_in) begin
            if (clear_all) begin
                m_pend = '{0, 0, 0};
                m_next = 0;
                m_cv   = 0;
            end else begin
                if (w >= 0) begin
                    m_cv      = 1;
                    m_cval    = m_val[w];
                    m_cdst    = m_dst[w];
                    m_csrc    = w;
                    m_pend[w] = 0;
                    m_next    = (w + 1) % 3;
                end else begin
                    m_cv = 0;
                end
                for (int i = 0; i < 3; i++) begin
                    if (vin[i] && rexp[i]) begin
                        m_pend[i] = 1;
                        m_val[i]  = ival[i];
                        m_dst[i]  = idst[i];
                    end
                end
            end
        end
        @(negedge clk_in);
        chk("cdb_valid", {63'd0, bus.cdb_valid}, {63'd0, m_cv});
        chk("cdb_value", {32'd0, bus.cdb_value}, {32'd0, m_cval});
        chk("cdb_dest",  {60'd0, bus.cdb_dest},  64'(m_cdst));
        chk("cdb_src",   {62'd0, bus.cdb_src},   64'(m_csrc));
    endtask

    task automatic do_reset();
        rst_in = 1; idle();
        tick();
        rst_in = 0;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; clear_all = 0;
        idle();
        m_pend = '{0, 0, 0};
        m_val  = '{0, 0, 0};
        m_dst  = '{0, 0, 0};
        m_next = 0;
        m_cv = 0; m_cval = 0; m_cdst = 0; m_csrc = 0;
        @(negedge clk_in);

        // reset held two cycles
        tick(); tick();
        rst_in = 0;
        tick();
        chk("t1_ready_all", {61'd0, bus.sb_ready, bus.lb_ready, bus.rs_ready}, 64'h7);

        // single ALU result
        offer(1, 32'h1234, 5, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        chk("t2_valid", {63'd0, bus.cdb_valid}, 64'd1);
        chk("t2_value", {32'd0, bus.cdb_value}, 64'h1234);
        chk("t2_dest",  {60'd0, bus.cdb_dest},  64'd5);
        chk("t2_src",   {62'd0, bus.cdb_src},   64'd0);
        tick();
        chk("t2_pulse", {63'd0, bus.cdb_valid}, 64'd0);

        // all three at once from rr_ptr=0
        do_reset();
        offer(1, 11, 1, 1, 22, 2, 1, 3);
        tick();
        idle();
        tick();
        chk("t3_first",  {62'd0, bus.cdb_src}, 64'd0);
        tick();
        chk("t3_second", {62'd0, bus.cdb_src}, 64'd1);
        chk("t3_lbval",  {32'd0, bus.cdb_value}, 64'd22);
        tick();
        chk("t3_third",  {62'd0, bus.cdb_src}, 64'd2);
        chk("t3_sbval",  {32'd0, bus.cdb_value}, 64'd0);
        tick();

        // rs and lb saturating
        for (int c = 0; c < 10; c++) begin
            offer(1, $urandom, $urandom_range(0, 15), 1, $urandom, $urandom_range(0, 15), 0, 0);
            tick();
        end
        idle();
        tick(); tick(); tick();

        // flush with three full slots and a dropped lb offer
        offer(1, 32'hA1, 7, 1, 32'hB2, 8, 1, 9);
        tick();
        clear_all = 1;
        offer(0, 0, 0, 1, 32'h99, 4, 0, 0);
        tick();
        chk("t5_flush", {63'd0, bus.cdb_valid}, 64'd0);
        clear_all = 0;
        idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t5_quiet", {63'd0, bus.cdb_valid}, 64'd0);
        end

        // pause with two full slots
        offer(1, 32'hC3, 10, 0, 0, 0, 1, 11);
        tick();
        idle();
        rdy_in = 0;
        offer(1, 32'hDEAD, 12, 1, 32'hBEEF, 13, 1, 14);
        for (int c = 0; c < 3; c++) tick();
        rdy_in = 1;
        idle();
        tick();
        chk("t6_resume_rs", {62'd0, bus.cdb_src}, 64'd0);
        tick();
        chk("t6_resume_sb", {62'd0, bus.cdb_src}, 64'd2);
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            rst_in    = ($urandom_range(0, 99) == 0);
            rdy_in    = ($urandom_range(0, 99) < 85);
            clear_all = ($urandom_range(0, 99) < 4);
            offer($urandom_range(0, 1), $urandom, $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, 15));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
